// File: rtl/ap_fifo_chan_share.sv
// Shares one ap_fifo-style IP among NCH stream channels: burst round-robin on the
// input side, in-order tag FIFO steering each IP result back to its source channel.
module ap_fifo_chan_share #(
  parameter int NCH       = 3,
  parameter int W         = 128,
  parameter int BURST     = 16,
  parameter int TAG_DEPTH = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [NCH*W-1:0] ch_in_dout,
  input  logic [NCH-1:0]   ch_in_empty_n,
  output logic [NCH-1:0]   ch_in_read,
  output logic [NCH*W-1:0] ch_out_din,
  input  logic [NCH-1:0]   ch_out_full,
  output logic [NCH-1:0]   ch_out_write,
  output logic [W-1:0]     ip_in_dout,
  output logic             ip_in_empty_n,
  input  logic             ip_in_read,
  input  logic [W-1:0]     ip_out_din,
  output logic             ip_out_full_n,
  input  logic             ip_out_write,
  output logic [2:0]       grant_id,
  output logic             err_orphan
);
  localparam int CW = $clog2(BURST + 1);
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [2:0]     g, g_nxt, last, last_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [W-1:0]   hold, lane_g;
  logic           hold_vld;
  logic [2:0]     tag_mem [2**AW];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    tag_cnt;
  logic [2:0]     head;
  logic [7:0]     req_pad, full_pad;
  logic           tag_full, tag_empty, slot, load, pop, found;
  logic [3:0]     sum;

  assign req_pad   = 8'(ch_in_empty_n);
  assign full_pad  = 8'(ch_out_full);
  assign tag_full  = (tag_cnt == (AW+1)'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign head      = tag_mem[rd_ptr];
  assign slot      = (!hold_vld || ip_in_read) && !tag_full;

  // Handshakes are held off while reset is asserted so no channel sees a transfer.
  assign load          = ap_rst_n && (state == GRANT) && slot && req_pad[g];
  assign ip_out_full_n = ap_rst_n && !tag_empty && !full_pad[head];
  assign pop           = ip_out_write && ip_out_full_n;
  assign ip_in_empty_n = ap_rst_n && hold_vld;
  assign ip_in_dout    = hold;
  assign ch_out_din    = {NCH{ip_out_din}};
  assign grant_id      = g;

  always_comb begin
    ch_in_read   = '0;
    ch_out_write = '0;
    lane_g       = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_in_read[i]   = load && (g == 3'(i));
      ch_out_write[i] = pop && (head == 3'(i));
      if (g == 3'(i)) lane_g = ch_in_dout[i*W +: W];
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last;
    cnt_nxt   = cnt;
    found     = 1'b0;
    sum       = '0;
    case (state)
      IDLE: begin
        // Scan starts just past the last grant, so the previous owner is checked last.
        for (int k = 1; k <= NCH; k++) begin
          sum = 4'(last) + 4'(k);
          if (sum >= 4'(NCH)) sum = sum - 4'(NCH);
          if (!found && req_pad[sum[2:0]]) begin
            found     = 1'b1;
            g_nxt     = sum[2:0];
            last_nxt  = sum[2:0];
            cnt_nxt   = '0;
            state_nxt = GRANT;
          end
        end
      end
      GRANT: begin
        if (slot) begin
          if (req_pad[g]) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == CW'(BURST)) state_nxt = IDLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      g          <= '0;
      last       <= 3'(NCH - 1);
      cnt        <= '0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        hold     <= lane_g;
        hold_vld <= 1'b1;
      end else if (ip_in_read) begin
        hold_vld <= 1'b0;
      end
      if (load) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({load, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (ip_out_write && !ip_out_full_n) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (load) tag_mem[wr_ptr] <= g;
  end
endmodule

// File: tb/tb_ap_fifo_chan_share.sv
// Bench for ap_fifo_chan_share: channel/IP models driven per cycle, checked against
// per-channel in-order queues, an in-order tag queue and directed corner sequences.
module tb_ap_fifo_chan_share;
  localparam int NCH = 3, W = 16, BURST = 4, TAG_DEPTH = 4;

  logic             ap_clk = 0, ap_rst_n = 0;
  logic [NCH*W-1:0] ch_in_dout = '0, ch_out_din;
  logic [NCH-1:0]   ch_in_empty_n = '0, ch_in_read, ch_out_full = '0, ch_out_write;
  logic [W-1:0]     ip_in_dout, ip_out_din = '0;
  logic             ip_in_empty_n, ip_in_read = 0, ip_out_full_n, ip_out_write = 0;
  logic [2:0]       grant_id;
  logic             err_orphan;

  ap_fifo_chan_share #(.NCH(NCH), .W(W), .BURST(BURST), .TAG_DEPTH(TAG_DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .ch_in_dout(ch_in_dout), .ch_in_empty_n(ch_in_empty_n), .ch_in_read(ch_in_read),
    .ch_out_din(ch_out_din), .ch_out_full(ch_out_full), .ch_out_write(ch_out_write),
    .ip_in_dout(ip_in_dout), .ip_in_empty_n(ip_in_empty_n), .ip_in_read(ip_in_read),
    .ip_out_din(ip_out_din), .ip_out_full_n(ip_out_full_n), .ip_out_write(ip_out_write),
    .grant_id(grant_id), .err_orphan(err_orphan));

  always #5 ap_clk = ~ap_clk;

  typedef struct { int cyc; int ch; logic [W-1:0] data; } vec_t;

  int total = 0, bad = 0, cyc = 0;
  logic [NCH-1:0] avail = '0, full_k = '0;
  bit rd_on = 0, wr_on = 0, force_wr = 0, rst_k = 0, err_m = 0;

  logic [W-1:0] inq [NCH][$];
  logic [W-1:0] expq [NCH][$];
  logic [W-1:0] ipq[$], holdq[$], ip_seen[$];
  int tagq[$], load_cyc[$], load_ch[$], pop_cyc[$], wr_cyc[$], wr_ch[$];
  int recv [NCH], sent [NCH], seq [NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    int c;
    logic exp_ofn;
    logic [W-1:0] got;
    @(negedge ap_clk);
    ap_rst_n = !rst_k;
    for (int i = 0; i < NCH; i++) begin
      ch_in_empty_n[i] = avail[i] && (inq[i].size() > 0);
      ch_in_dout[i*W +: W] = (inq[i].size() > 0) ? inq[i][0] : '0;
    end
    ch_out_full = full_k;
    ip_in_read  = rd_on;
    #1;
    ip_out_write = force_wr || (wr_on && ipq.size() > 0 && ip_out_full_n);
    ip_out_din   = force_wr ? 16'hDEAD : ((ipq.size() > 0) ? ipq[0] : '0);
    #1;
    exp_ofn = !rst_k && tagq.size() > 0 && !full_k[tagq[0]];
    chk("err_orphan", err_orphan, err_m);
    chk("ip_out_full_n", ip_out_full_n, exp_ofn);
    chk("ip_in_empty_n", ip_in_empty_n, !rst_k && holdq.size() > 0);
    chk("rd_onehot", $onehot0(ch_in_read), 1);
    chk("wr_onehot", $onehot0(ch_out_write), 1);
    chk("wr_fire", ch_out_write != 0, ip_out_write && exp_ofn);
    if (!rst_k && ip_out_write && !exp_ofn) err_m = 1;
    if (ch_out_write != 0) begin
      c = 0;
      for (int i = 0; i < NCH; i++) if (ch_out_write[i]) c = i;
      if (tagq.size() == 0) chk("wr_has_tag", 0, 1);
      else begin chk("wr_route", c, tagq[0]); void'(tagq.pop_front()); end
      got = ch_out_din[c*W +: W];
      chk("wr_pass", got, ip_out_din);
      if (expq[c].size() == 0) chk("wr_expected", 0, 1);
      else begin chk("wr_data", got, expq[c][0]); void'(expq[c].pop_front()); end
      recv[c]++;
      wr_cyc.push_back(cyc);
      wr_ch.push_back(c);
      if (!force_wr && ipq.size() > 0) void'(ipq.pop_front());
    end
    if (ip_in_read && ip_in_empty_n) begin
      if (holdq.size() > 0) begin chk("ip_in_dout", ip_in_dout, holdq[0]); void'(holdq.pop_front()); end
      ipq.push_back(ip_in_dout);
      ip_seen.push_back(ip_in_dout);
      pop_cyc.push_back(cyc);
    end
    for (int i = 0; i < NCH; i++) if (ch_in_read[i]) begin
      chk("rd_req", ch_in_empty_n[i], 1);
      if (inq[i].size() > 0) begin
        holdq.push_back(inq[i][0]);
        expq[i].push_back(inq[i][0]);
        void'(inq[i].pop_front());
      end
      tagq.push_back(i);
      load_cyc.push_back(cyc);
      load_ch.push_back(i);
    end
    chk("tag_bound", tagq.size() <= TAG_DEPTH, 1);
    if (rst_k) begin
      ipq.delete(); holdq.delete(); tagq.delete(); err_m = 0;
      for (int i = 0; i < NCH; i++) expq[i].delete();
    end
    cyc++;
  endtask

  task automatic clear_logs();
    load_cyc.delete(); load_ch.delete(); pop_cyc.delete(); ip_seen.delete();
    wr_cyc.delete(); wr_ch.delete();
    for (int i = 0; i < NCH; i++) begin recv[i] = 0; sent[i] = 0; seq[i] = 0; end
    cyc = 0;
  endtask

  task automatic do_reset();
    rst_k = 1; avail = '0; rd_on = 0; wr_on = 0; force_wr = 0; full_k = '0;
    step();
    rst_k = 0;
    for (int i = 0; i < NCH; i++) inq[i].delete();
    clear_logs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1 [10];
    vec_t t2 [24];
    int   offs [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
    int   n, k, waited;
    bit   busy;

    // single channel, burst release with bubble
    for (int i = 0; i < 10; i++) begin
      t1[i].cyc = offs[i]; t1[i].ch = 1; t1[i].data = W'(i + 1);
    end
    do_reset();
    for (int i = 0; i < 10; i++) inq[1].push_back(W'(i + 1));
    avail = '1; rd_on = 1; wr_on = 1;
    step();
    chk("rst_ch_in_read", ch_in_read, 0);
    chk("rst_grant_id", grant_id, 0);
    steps(24);
    chk("t1_loads", load_cyc.size(), 10);
    chk("t1_ip_words", ip_seen.size(), 10);
    n = (load_cyc.size() < 10) ? load_cyc.size() : 10;
    for (int i = 0; i < n; i++) begin
      chk("t1_load_cyc", load_cyc[i], t1[i].cyc);
      chk("t1_load_ch", load_ch[i], t1[i].ch);
    end
    n = (ip_seen.size() < 10) ? ip_seen.size() : 10;
    for (int i = 0; i < n; i++) begin
      chk("t1_ip_data", ip_seen[i], t1[i].data);
      chk("t1_ip_cyc", pop_cyc[i], t1[i].cyc + 1);
    end
    chk("t1_recv1", recv[1], 10);
    chk("t1_grant_id", grant_id, 1);

    // three channels, round-robin bursts
    for (int i = 0; i < 24; i++) begin
      t2[i].ch = (i / 4) % 3;
      k = (i / 12) * 4 + (i % 4) + 1;
      t2[i].data = W'(t2[i].ch * 256 + k);
      t2[i].cyc = 0;
    end
    do_reset();
    for (int c = 0; c < NCH; c++)
      for (int j = 1; j <= 8; j++) inq[c].push_back(W'(c * 256 + j));
    avail = '1; rd_on = 1; wr_on = 1;
    steps(60);
    chk("t2_ip_words", ip_seen.size(), 24);
    n = (ip_seen.size() < 24) ? ip_seen.size() : 24;
    for (int i = 0; i < n; i++) begin
      chk("t2_ip_data", ip_seen[i], t2[i].data);
      chk("t2_load_ch", load_ch[i], t2[i].ch);
    end
    for (int c = 0; c < NCH; c++) chk("t2_recv", recv[c], 8);

    // tag FIFO full stalls the input side
    do_reset();
    for (int j = 1; j <= 8; j++) inq[0].push_back(W'(16'h0100 + j));
    avail = '1; rd_on = 1; wr_on = 0;
    steps(10);
    chk("t3_loads_full", load_cyc.size(), 4);
    wr_on = 1;
    step();
    wr_on = 0;
    step();
    chk("t3_one_write", wr_cyc.size(), 1);
    if (wr_cyc.size() > 0) chk("t3_write_cyc", wr_cyc[0], 10);
    chk("t3_loads_after", load_cyc.size(), 5);
    if (load_cyc.size() > 4) chk("t3_reload_cyc", load_cyc[4], 11);
    wr_on = 1;
    steps(30);
    chk("t3_recv0", recv[0], 8);

    // head-of-line stall on a full output FIFO
    do_reset();
    inq[2].push_back(16'h0201);
    avail = '1; rd_on = 1; wr_on = 1; full_k = 3'b100;
    steps(8);
    chk("t4_no_write", wr_cyc.size(), 0);
    chk("t4_ofn_low", ip_out_full_n, 0);
    full_k = '0;
    step();
    chk("t4_write", wr_cyc.size(), 1);
    if (wr_cyc.size() > 0) begin
      chk("t4_write_ch", wr_ch[0], 2);
      chk("t4_write_cyc", wr_cyc[0], 8);
    end

    // orphan result with no tag
    do_reset();
    step();
    force_wr = 1;
    step();
    chk("t5_no_write", ch_out_write, 0);
    force_wr = 0;
    step();
    chk("t5_err_set", err_orphan, 1);
    steps(3);
    chk("t5_err_sticky", err_orphan, 1);
    do_reset();
    step();
    chk("t5_err_cleared", err_orphan, 0);

    // reset mid-burst with tags outstanding
    do_reset();
    for (int j = 1; j <= 8; j++) inq[0].push_back(W'(16'h0100 + j));
    for (int j = 1; j <= 4; j++) inq[1].push_back(W'(16'h0200 + j));
    avail = '1; rd_on = 1; wr_on = 0;
    steps(4);
    chk("t6_tags_before", tagq.size(), 3);
    rst_k = 1;
    step();
    rst_k = 0;
    step();
    chk("t6_rd_idle", ch_in_read, 0);
    chk("t6_wr_idle", ch_out_write, 0);
    chk("t6_ip_empty", ip_in_empty_n, 0);
    chk("t6_ofn", ip_out_full_n, 0);
    chk("t6_grant_id", grant_id, 0);
    step();
    chk("t6_regrant0", ch_in_read, 3'b001);
    wr_on = 1;
    steps(80);
    chk("t6_drained", inq[0].size() + inq[1].size() + tagq.size(), 0);

    // randomized traffic against the queue model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 7) == 0) begin
        inq[c].push_back(W'(c * 4096 + seq[c]));
        seq[c]++; sent[c]++;
      end
      for (int c = 0; c < NCH; c++) avail[c] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) full_k[c] = ($urandom_range(0, 9) == 0);
      rd_on = ($urandom_range(0, 9) < 7);
      wr_on = ($urandom_range(0, 9) < 7);
      step();
    end
    avail = '1; full_k = '0; rd_on = 1; wr_on = 1;
    waited = 0;
    busy = 1;
    while (busy && waited < 5000) begin
      step();
      waited++;
      busy = (tagq.size() > 0) || (holdq.size() > 0);
      for (int c = 0; c < NCH; c++) if (inq[c].size() > 0) busy = 1;
    end
    chk("rnd_drain_timeout", busy, 0);
    for (int c = 0; c < NCH; c++) chk("rnd_recv", recv[c], sent[c]);
    chk("rnd_no_orphan", err_orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
